// File: rtl/dsmem_reader.sv
// Burst reader for a shift-register history memory: emits the newest
// min(len, fill) entries oldest-first through a valid/ready output register.
module dsmem_reader #(
  parameter int MSBD = 3,
  parameter int MSBA = 3,
  parameter int LAST = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            shift,
  input  logic            start,
  input  logic [MSBA+1:0] len,
  input  logic [MSBD:0]   mem_q,
  output logic [MSBA:0]   addr,
  output logic            shift_hold,
  output logic [MSBD:0]   dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam logic [MSBA+1:0] DEPTH = (MSBA+2)'(LAST + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t          state_q;
  logic [MSBA+1:0] fill_q, fill_d;
  logic [MSBA:0]   idx_q;
  logic [MSBD:0]   dout_q;
  logic            doutValid_q;
  logic            busy_q;
  logic            done_q;
  logic            overrun_q;
  logic [MSBA+1:0] effLen;
  logic [MSBA+1:0] effLenM1;

  // Fill tracks the writer independently of the FSM and saturates at full depth.
  always_comb begin
    fill_d = fill_q;
    if (shift && (fill_q != DEPTH)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_comb begin
    effLen = len;
    if (fill_q < effLen) begin
      effLen = fill_q;
    end
    if (DEPTH < effLen) begin
      effLen = DEPTH;
    end
    effLenM1 = effLen - 1'b1;
  end

  // idx doubles as the memory address, so it is left at 0 whenever not bursting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      idx_q       <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      fill_q <= fill_d;
      done_q <= 1'b0;
      if (shift && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            overrun_q <= 1'b0;
            if (effLen != '0) begin
              idx_q   <= effLenM1[MSBA:0];
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        FETCH: begin
          dout_q      <= mem_q;
          doutValid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (dout_ready) begin
            doutValid_q <= 1'b0;
            if (idx_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign addr       = idx_q;
  assign shift_hold = busy_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/dsmem_reader.md
DSMEM_READER -- requirements
Module: dsmem_reader

Interface
REQ-001 Parameter MSBD, default 3, MSB of data word (width MSBD+1).
REQ-002 Parameter MSBA, default 3, MSB of history address (width MSBA+1).
REQ-003 Parameter LAST, default 15, index of last history entry (depth LAST+1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 shift  input  1  writer push strobe, same signal that drives the history memory; used to track fill.
REQ-007 start  input  1  request a burst read; sampled only in IDLE.
REQ-008 len  input  MSBA+2  requested word count, 0..LAST+1.
REQ-009 mem_q  input  MSBD+1  combinational read data from history memory for addr.
REQ-010 addr  output  MSBA+1  history offset; 0 = newest entry, k = k-th older entry.
REQ-011 shift_hold  output  1  request to gate writer shift; high while busy.
REQ-012 dout  output  MSBD+1  registered output word.
REQ-013 dout_valid  output  1  dout holds a word not yet accepted.
REQ-014 dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-015 busy  output  1  burst in progress (FETCH or SEND).
REQ-016 done  output  1  one-cycle pulse at burst end.
REQ-017 overrun  output  1  sticky: shift seen while shift_hold high; cleared on accepted start.

Function
REQ-018 fill counter SHALL increment on each shift cycle, saturating at LAST+1; range 0..LAST+1.
REQ-019 eff_len SHALL equal min(len, fill, LAST+1), computed when start is sampled.
REQ-020 States SHALL be IDLE, FETCH, SEND, DONE.
REQ-021 IDLE: start=1 with eff_len>0 -> FETCH, idx <= eff_len-1, overrun <= 0.
REQ-022 IDLE: start=1 with eff_len=0 -> DONE, no word emitted, overrun <= 0.
REQ-023 FETCH: addr = idx; at edge dout <= mem_q, dout_valid <= 1, -> SEND.
REQ-024 SEND: addr = idx held; dout and dout_valid stable until dout_ready=1.
REQ-025 SEND with dout_ready=1: dout_valid <= 0; idx=0 -> DONE, else idx <= idx-1, -> FETCH.
REQ-026 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-027 Words SHALL be emitted oldest first: addresses eff_len-1 down to 0.
REQ-028 Throughput SHALL be one word per two cycles with dout_ready held high; first dout_valid two cycles after start.
REQ-029 addr SHALL be 0 in IDLE and DONE.
REQ-030 busy and shift_hold SHALL be 1 in FETCH and SEND, 0 otherwise.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 shift while shift_hold=1 SHALL set overrun and still update fill; burst addresses are not corrected.
REQ-033 fill SHALL be updated in every state, including when shift and start coincide; eff_len uses fill before that cycle's increment.
REQ-034 len > LAST+1 SHALL be clamped to LAST+1.

Reset
REQ-035 rst=1 SHALL force IDLE, fill=0, idx=0, addr=0, dout=0, dout_valid=0, busy=0, shift_hold=0, done=0, overrun=0.
REQ-036 rst SHALL take priority over all other inputs, including mid-burst; no done pulse on abort.

Verification
REQ-037 After reset, 3 shifts of d=1,2,3, start len=3, ready=1 -> dout 1,2,3 on addr 2,1,0, done one cycle after the third accept.
REQ-038 After reset, 20 shifts, start len=16 -> fill=16, 16 words emitted oldest first, addr 15..0.
REQ-039 After reset, 2 shifts, start len=5 -> only 2 words emitted; start len=0 -> done next cycle, dout_valid never high.
REQ-040 Burst with dout_ready low 4 cycles in SEND -> dout, addr, dout_valid unchanged throughout; advance on first ready.
REQ-041 shift pulsed during busy -> overrun=1 until next accepted start, fill incremented.
REQ-042 rst asserted in SEND -> next cycle all outputs 0, state IDLE, no done pulse.
